serial_adder_seq: RTL and testbench

- Sequencer that performs a WIDTH-bit addition by time-multiplexing one internal 3-bit ripple slice.
- The slice is a half/full-adder chain with carry-in.
- One 3-bit chunk is processed per clock, LSB chunk first, with the carry held in a register between chunks.
- Sits between a requester and a consumer using valid/ready handshakes on both sides. This trades latency for area when wide sums are needed rarely.

---
 rtl/serial_adder_seq.sv | 86 ++++++++
 tb/tb_serial_adder_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: WIDTH-bit adder built from one 3-bit ripple slice reused once per clock
module serial_adder_seq #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NSLICE = WIDTH / 3;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   if ((WIDTH % 3) != 0 || WIDTH < 3 || WIDTH > 48) begin : g_bad_width
      $error("serial_adder_seq: WIDTH must be a multiple of 3 in 3..48");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r, b_r;
   logic             carry_r;
   logic [IW-1:0]    idx;
   logic [2:0]       as, bs, p, g, s;
   logic             c1, c2, c3;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   // 3-bit ripple slice on the chunk selected by idx, carry-in from the carry register
   always_comb begin
      as = a_r[3*idx +: 3];
      bs = b_r[3*idx +: 3];
      p  = as ^ bs;
      g  = as & bs;
      c1 = g[0] | (p[0] & carry_r);
      c2 = g[1] | (p[1] & c1);
      c3 = g[2] | (p[2] & c2);
      s  = {p[2] ^ c2, p[1] ^ c1, p[0] ^ carry_r};
   end

   // Sequencer: accept operands, step one chunk per clock, hold result until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r     <= a;
               b_r     <= b;
               carry_r <= cin;
               idx     <= '0;
               sum     <= '0;
               cout    <= 1'b0;
               state   <= RUN;
            end
            RUN: begin
               sum[3*idx +: 3] <= s;
               carry_r         <= c3;
               idx             <= idx + 1'b1;
               if (idx == LAST) begin
                  cout  <= c3;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed table-driven checks of the serial adder sequencer
module tb_serial_adder_seq;
   localparam int W  = 12;
   localparam int NS = W / 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         in_ready, out_valid, cout, busy;
   logic [W-1:0] sum;

   int total = 0;
   int passed = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t v[7];

   serial_adder_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Waits at negedges for out_valid; lat = posedges since accept, low = negedges seen with in_ready low
   task automatic wait_result(input bit drop_valid, output int lat, output int low);
      lat = -1;
      low = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (j == 0 && drop_valid) in_valid = 1'b0;
         if (!in_ready) low++;
         if (out_valid) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output logic [W-1:0] s, output logic c, output int lat, output int low,
                         output logic rdy_after);
      @(negedge clk);
      a = av;
      b = bv;
      cin = cv;
      in_valid = 1'b1;
      @(posedge clk);
      wait_result(1'b1, lat, low);
      s = sum;
      c = cout;
      @(negedge clk);
      rdy_after = in_ready;
   endtask

   initial begin
      logic [W-1:0] s;
      logic         c, r;
      int           lat, low, bad;

      v[0] = '{12'h123, 12'h456, 1'b0, 12'h579, 1'b0};
      v[1] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
      v[2] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1};
      v[3] = '{12'h800, 12'h800, 1'b0, 12'h000, 1'b1};
      v[4] = '{12'h000, 12'h000, 1'b1, 12'h001, 1'b0};
      v[5] = '{12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1};
      v[6] = '{12'h0A5, 12'h15A, 1'b0, 12'h1FF, 1'b0};

      #1;
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(cout), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_out_ready_ignored", 32'(busy), 0);

      for (int i = 0; i < 7; i++) begin
         run_op(v[i].a, v[i].b, v[i].ci, s, c, lat, low, r);
         check($sformatf("v%0d_latency", i), 32'(lat), NS);
         check($sformatf("v%0d_in_ready_low", i), 32'(low), NS + 1);
         check($sformatf("v%0d_sum", i), 32'(s), 32'(v[i].s));
         check($sformatf("v%0d_cout", i), 32'(c), 32'(v[i].co));
         check($sformatf("v%0d_in_ready_after", i), 32'(r), 1);
      end

      // Back-pressure with operand changes and a pending in_valid
      @(negedge clk);
      out_ready = 1'b0;
      a = 12'h0A5;
      b = 12'h15A;
      cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 12'hFFF;
      wait_result(1'b0, lat, low);
      check("bp_latency", 32'(lat + 1), NS);
      check("bp_sum", 32'(sum), 32'h200);
      check("bp_cout", 32'(cout), 0);
      bad = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (sum !== 12'h200 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      check("bp_stable", 32'(bad), 0);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_in_ready", 32'(in_ready), 1);
      check("bp_idle_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("bp_pending_accepted", 32'(busy), 1);
      in_valid = 1'b0;
      wait_result(1'b0, lat, low);
      check("bp_pending_latency", 32'(lat + 1), NS);
      check("bp_pending_sum", 32'(sum), 32'h15A);
      check("bp_pending_cout", 32'(cout), 1);
      @(negedge clk);

      // Asynchronous reset after two slice cycles
      a = 12'h777;
      b = 12'h777;
      cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid_busy_before", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum", 32'(sum), 0);
      check("mid_rst_cout", 32'(cout), 0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("mid_rst_no_result", 32'(bad), 0);
      run_op(12'h007, 12'h001, 1'b0, s, c, lat, low, r);
      check("post_rst_latency", 32'(lat), NS);
      check("post_rst_sum", 32'(s), 32'h008);
      check("post_rst_cout", 32'(c), 0);
      check("post_rst_in_ready", 32'(r), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
